// File: rtl/tetris_row_clear_scanner_pkg.sv
// rtl/tetris_row_clear_scanner_pkg.sv - shared playfield dimensions, scanner states and NOR helper
package tetris_row_clear_scanner_pkg;

  localparam int DEF_NR_OF_ROWS    = 20;
  localparam int DEF_NR_OF_COLUMNS = 10;
  localparam int DEF_ADDR_WIDTH    = 5;
  localparam int NOR_WIDTH         = 5;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_READ        = 3'd1,
    S_CHECK       = 3'd2,
    S_SHIFT_READ  = 3'd3,
    S_SHIFT_WRITE = 3'd4,
    S_CLEAR_TOP   = 3'd5,
    S_FINISH      = 3'd6
  } state_t;

  // Library 5-input NOR; a set bubble bit inverts that input before the reduction.
  function automatic logic nor5(input logic [NOR_WIDTH-1:0] cells,
                                input logic [NOR_WIDTH-1:0] bubbles);
    return ~|(cells ^ bubbles);
  endfunction

endpackage

// File: rtl/tetris_row_clear_scanner_row_occupancy_detect.sv
// rtl/tetris_row_clear_scanner_row_occupancy_detect.sv - row full/empty flags from chained 5-input NORs
module row_occupancy_detect
  import tetris_row_clear_scanner_pkg::*;
#(
  parameter int NR_OF_COLUMNS = DEF_NR_OF_COLUMNS
) (
  input  logic [NR_OF_COLUMNS-1:0] cells,
  output logic                     row_full,
  output logic                     row_empty
);

  localparam int GROUPS = (NR_OF_COLUMNS + NOR_WIDTH - 1) / NOR_WIDTH;
  localparam int PADDED = GROUPS * NOR_WIDTH;

  // Padding is neutral: 0 for the empty test, 1 for the full test (inverted by the bubble).
  logic [PADDED-1:0] pad_empty;
  logic [PADDED-1:0] pad_full;

  always_comb begin
    pad_empty = '0;
    pad_full  = '1;
    pad_empty[NR_OF_COLUMNS-1:0] = cells;
    pad_full[NR_OF_COLUMNS-1:0]  = cells;
  end

  logic [GROUPS:0] full_chain;
  logic [GROUPS:0] empty_chain;

  assign full_chain[0]  = 1'b1;
  assign empty_chain[0] = 1'b1;

  for (genvar g = 0; g < GROUPS; g++) begin : g_chain
    // Two bubbled inputs on a NOR form the AND that links one group into the chain.
    assign full_chain[g+1]  = nor5({3'b000, full_chain[g],
                                    nor5(pad_full[g*NOR_WIDTH +: NOR_WIDTH], 5'b11111)}, 5'b00011);
    assign empty_chain[g+1] = nor5({3'b000, empty_chain[g],
                                    nor5(pad_empty[g*NOR_WIDTH +: NOR_WIDTH], 5'b00000)}, 5'b00011);
  end

  assign row_full  = full_chain[GROUPS];
  assign row_empty = empty_chain[GROUPS];

endmodule

// File: rtl/tetris_row_clear_scanner.sv
// rtl/tetris_row_clear_scanner.sv - bottom-up full-row scan and collapse of the playfield RAM
module tetris_row_clear_scanner
  import tetris_row_clear_scanner_pkg::*;
#(
  parameter int NR_OF_ROWS    = DEF_NR_OF_ROWS,
  parameter int NR_OF_COLUMNS = DEF_NR_OF_COLUMNS,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
  input  logic                     GlobalClock,
  input  logic                     Reset,
  input  logic                     Start,
  output logic [ADDR_WIDTH-1:0]    Rd_Addr,
  input  logic [NR_OF_COLUMNS-1:0] Rd_Data,
  output logic                     Wr_En,
  output logic [ADDR_WIDTH-1:0]    Wr_Addr,
  output logic [NR_OF_COLUMNS-1:0] Wr_Data,
  output logic                     Busy,
  output logic                     Done,
  output logic [ADDR_WIDTH-1:0]    Lines_Cleared
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(NR_OF_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_LINES = ADDR_WIDTH'(NR_OF_ROWS);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   cur;
  logic [ADDR_WIDTH-1:0]   sp;
  logic [ADDR_WIDTH-1:0]   lines;
  logic                    row_full;
  logic                    row_empty;

  row_occupancy_detect #(.NR_OF_COLUMNS(NR_OF_COLUMNS)) u_detect (
    .cells     (Rd_Data),
    .row_full  (row_full),
    .row_empty (row_empty)
  );

  always_ff @(posedge GlobalClock) begin
    if (Reset) begin
      state <= S_IDLE;
      cur   <= '0;
      sp    <= '0;
      lines <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: if (Start) begin
          cur   <= LAST_ROW;
          lines <= '0;
        end
        S_CHECK: begin
          if (row_full) begin
            if (lines != MAX_LINES) lines <= lines + ONE;
            sp <= cur;
          end else if (!row_empty && cur != '0) begin
            cur <= cur - ONE;
          end
        end
        S_SHIFT_WRITE: sp <= sp - ONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    Rd_Addr    = '0;
    Wr_En      = 1'b0;
    Wr_Addr    = '0;
    Wr_Data    = '0;
    Busy       = 1'b1;
    Done       = 1'b0;
    case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Start) next_state = S_READ;
      end
      S_READ: begin
        Rd_Addr    = cur;
        next_state = S_CHECK;
      end
      S_CHECK: begin
        if (row_full)                     next_state = S_SHIFT_READ;
        else if (row_empty || cur == '0)  next_state = S_FINISH;
        else                              next_state = S_READ;
      end
      S_SHIFT_READ: begin
        if (sp == '0) begin
          next_state = S_CLEAR_TOP;
        end else begin
          Rd_Addr    = sp - ONE;
          next_state = S_SHIFT_WRITE;
        end
      end
      S_SHIFT_WRITE: begin
        Wr_En      = 1'b1;
        Wr_Addr    = sp;
        Wr_Data    = Rd_Data;
        next_state = S_SHIFT_READ;
      end
      // cur is left alone so the row that dropped into it is checked again.
      S_CLEAR_TOP: begin
        Wr_En      = 1'b1;
        next_state = S_READ;
      end
      S_FINISH: begin
        Busy       = 1'b0;
        Done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        Busy       = 1'b0;
        next_state = S_IDLE;
      end
    endcase
  end

  assign Lines_Cleared = lines;

endmodule

// File: tb/tb_tetris_row_clear_scanner.sv
// tb/tb_tetris_row_clear_scanner.sv - scoreboard bench with a 1-cycle-latency 20x10 playfield RAM
module tb_tetris_row_clear_scanner;
  import tetris_row_clear_scanner_pkg::*;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int AW   = 5;
  localparam logic [COLS-1:0] FULL = 10'h3FF;

  typedef logic [ROWS-1:0][COLS-1:0] field_t;
  typedef struct packed {
    int     lines;
    int     cycles;
    int     writes;
    field_t rows;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] wr_data;
  logic            busy;
  logic            done;
  logic [AW-1:0]   lines_cleared;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int last_a = 0;
  int last_d = 0;
  exp_t sb[$];

  logic [COLS-1:0] mem [ROWS];
  logic            load = 1'b0;
  field_t          img = '0;

  tetris_row_clear_scanner dut (
    .GlobalClock   (clk),
    .Reset         (rst),
    .Start         (start),
    .Rd_Addr       (rd_addr),
    .Rd_Data       (rd_data),
    .Wr_En         (wr_en),
    .Wr_Addr       (wr_addr),
    .Wr_Data       (wr_data),
    .Busy          (busy),
    .Done          (done),
    .Lines_Cleared (lines_cleared)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= img[i];
    end else if (wr_en && int'(wr_addr) < ROWS) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= (int'(rd_addr) < ROWS) ? mem[rd_addr] : '0;
  end

  always @(negedge clk) begin
    if (wr_en && (dut.state inside {S_IDLE, S_READ, S_CHECK, S_FINISH})) viol++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: standard line compaction plus the scan's cycle/write cost per row visited.
  function automatic exp_t model(input field_t f);
    exp_t e;
    int   w = ROWS - 1;
    int   partials = 0;
    int   pairs = 0;
    bit   hit_empty = 0;
    bit   last_full = 0;
    e.lines = 0; e.cycles = 0; e.writes = 0; e.rows = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (f[r] == '0) begin hit_empty = 1; break; end
      pairs++;
      if (f[r] == FULL) begin
        e.lines++;
        e.cycles += 2 * (ROWS - 1 - partials) + 2;
        e.writes += ROWS - partials;
        last_full = 1;
      end else begin
        e.rows[w] = f[r];
        w--;
        partials++;
        last_full = 0;
      end
    end
    if (hit_empty || last_full) pairs++;
    e.cycles += 2 * pairs + 1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_field(input field_t f);
    img = f;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_scan(input string name, input field_t f, input int hold);
    exp_t e;
    int   n = 0;
    int   writes = 0;
    int   pulses = 0;
    load_field(f);
    sb.push_back(model(f));
    start = 1'b1;
    step();
    if (hold <= 1) start = 1'b0;
    check({name, "_busy"}, busy, 1);
    for (int c = 1; c <= 2000; c++) begin
      if (c >= hold) start = 1'b0;
      if (wr_en) begin writes++; last_a = wr_addr; last_d = wr_data; end
      if (done) begin n = c; pulses++; break; end
      step();
    end
    start = 1'b0;
    check({name, "_timeout"}, (n == 0), 0);
    e = sb.pop_front();
    check({name, "_lines"}, lines_cleared, e.lines);
    check({name, "_cycles"}, n, e.cycles);
    check({name, "_writes"}, writes, e.writes);
    check({name, "_busy_at_done"}, busy, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      if (done) pulses++;
    end
    check({name, "_done_pulses"}, pulses, 1);
    check({name, "_lines_held"}, lines_cleared, e.lines);
    for (int r = 0; r < ROWS; r++)
      check($sformatf("%s_row%0d", name, r), mem[r], e.rows[r]);
  endtask

  function automatic field_t random_field();
    field_t f = '0;
    int h = $urandom_range(1, ROWS);
    for (int r = ROWS - 1; r >= ROWS - h; r--)
      f[r] = ($urandom_range(0, 2) == 0) ? FULL : COLS'($urandom_range(1, 1022));
    return f;
  endfunction

  initial begin
    field_t f;
    int     seen;

    rst = 1'b1;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_state", dut.state, S_IDLE);
    rst = 1'b0;
    step();

    f = '0; f[19] = 10'h155;
    run_scan("partial_then_empty", f, 1);

    f = '0; f[19] = FULL; f[18] = 10'h001;
    run_scan("single_clear", f, 1);

    f = '0; for (int r = 16; r < 20; r++) f[r] = FULL; f[15] = 10'h200;
    run_scan("four_cascade", f, 1);

    f = '0; f[0] = FULL; for (int r = 1; r < 20; r++) f[r] = 10'h001 << (r % 10);
    run_scan("top_row_full", f, 1);
    check("top_clear_addr", last_a, 0);
    check("top_clear_data", last_d, 0);

    f = '0; for (int r = 0; r < 20; r++) f[r] = FULL;
    run_scan("all_full", f, 1);

    f = '0; for (int r = 0; r < 20; r++) f[r] = 10'h2AA ^ COLS'(r);
    run_scan("all_partial_hold", f, 10);

    for (int i = 0; i < 4; i++)
      run_scan($sformatf("random%0d", i), random_field(), 1);

    f = '0; for (int r = 16; r < 20; r++) f[r] = FULL; f[15] = 10'h200;
    load_field(f);
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (dut.state == S_SHIFT_WRITE) begin seen = 1; break; end
      step();
    end
    check("reach_shift_write", seen, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_wr_en", wr_en, 0);
    check("midreset_state", dut.state, S_IDLE);
    step();
    check("midreset_stays_idle", busy, 0);

    f = '0; f[19] = FULL; f[18] = 10'h001;
    run_scan("after_reset", f, 1);

    start = 1'b1;
    rst = 1'b1;
    step();
    start = 1'b0;
    rst = 1'b0;
    check("start_reset_state", dut.state, S_IDLE);
    check("start_reset_busy", busy, 0);
    step();
    check("start_reset_still_idle", busy, 0);

    check("wr_en_state", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
